// File: rtl/fifo_mipi_tx_ctrl.sv
// fifo_mipi_tx_ctrl: single-clock FIFO controller for a 2**AW x DW simple-dual-port RAM
// with a 1-cycle unregistered read latency. The push side writes the RAM directly.
// The pop side prefetches into a 2-entry output buffer, so a 1 word/clk stream has no bubbles.
module fifo_mipi_tx_ctrl #(
  parameter int unsigned AW       = 10,
  parameter int unsigned DW       = 32,
  parameter int unsigned AFULL_TH = 1008
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [AW-1:0] ram_aw,
  output logic [DW-1:0] ram_dw,
  output logic          ram_cew,
  output logic [AW-1:0] ram_ar,
  output logic          ram_cer,
  input  logic [DW-1:0] ram_qr,
  output logic          ram_rst,
  output logic [AW:0]   level,
  output logic          full,
  output logic          afull,
  output logic          empty
);

  localparam logic [AW:0] AFULL_LVL = AFULL_TH[AW:0];

  logic [AW:0]   r_wr_ptr, r_rd_ptr, r_pop_ptr, r_level;
  logic          r_full, r_afull, r_empty;
  logic [DW-1:0] r_ob0, r_ob1;
  logic          r_ob0_v, r_ob1_v, r_inflight;

  logic          w_clr, w_push, w_pop, w_cer;
  logic [1:0]    w_occ;
  logic [AW:0]   w_wr_nxt, w_pop_nxt, w_level_nxt;
  logic [DW-1:0] w_ob0_n, w_ob1_n;
  logic          w_ob0_v_n, w_ob1_v_n;

  // Handshakes, read-issue decision and next pointer/level values
  always_comb begin
    w_clr       = rst | flush;
    s_ready     = !r_full && !w_clr;
    w_push      = s_valid && s_ready;
    w_pop       = r_ob0_v && m_ready;
    w_occ       = {1'b0, r_ob0_v} + {1'b0, r_ob1_v} + {1'b0, r_inflight};
    // A read is issued only against the registered write pointer, so a slot is never
    // read in the cycle it is written.
    w_cer       = !w_clr && (r_rd_ptr != r_wr_ptr) && ((w_occ - {1'b0, w_pop}) < 2'd2);
    w_wr_nxt    = w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
    w_pop_nxt   = w_pop ? r_pop_ptr + 1'b1 : r_pop_ptr;
    w_level_nxt = w_wr_nxt - w_pop_nxt;
  end

  // Output buffer next state: shift on pop first, then land the returning read word
  // in the first free entry.
  always_comb begin
    w_ob0_n   = r_ob0;
    w_ob1_n   = r_ob1;
    w_ob0_v_n = r_ob0_v;
    w_ob1_v_n = r_ob1_v;
    if (w_pop) begin
      w_ob0_n   = r_ob1;
      w_ob0_v_n = r_ob1_v;
      w_ob1_v_n = 1'b0;
    end
    if (r_inflight) begin
      if (!w_ob0_v_n) begin
        w_ob0_n   = ram_qr;
        w_ob0_v_n = 1'b1;
      end else begin
        w_ob1_n   = ram_qr;
        w_ob1_v_n = 1'b1;
      end
    end
  end

  // Pointers, registered flags, in-flight marker and output buffer
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pop_ptr  <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_afull    <= 1'b0;
      r_empty    <= 1'b1;
      r_inflight <= 1'b0;
      r_ob0      <= '0;
      r_ob1      <= '0;
      r_ob0_v    <= 1'b0;
      r_ob1_v    <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_nxt;
      r_pop_ptr  <= w_pop_nxt;
      if (w_cer) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level    <= w_level_nxt;
      r_full     <= w_level_nxt[AW];
      r_afull    <= (w_level_nxt >= AFULL_LVL);
      r_empty    <= (w_level_nxt == '0);
      r_inflight <= w_cer;
      r_ob0      <= w_ob0_n;
      r_ob1      <= w_ob1_n;
      r_ob0_v    <= w_ob0_v_n;
      r_ob1_v    <= w_ob1_v_n;
    end
  end

  // Port mapping
  always_comb begin
    ram_aw  = r_wr_ptr[AW-1:0];
    ram_dw  = s_data;
    ram_cew = w_push;
    ram_ar  = r_rd_ptr[AW-1:0];
    ram_cer = w_cer;
    ram_rst = w_clr;
    m_valid = r_ob0_v;
    m_data  = r_ob0;
    level   = r_level;
    full    = r_full;
    afull   = r_afull;
    empty   = r_empty;
  end

endmodule

// File: tb/tb_fifo_mipi_tx_ctrl.sv
module tb_fifo_mipi_tx_ctrl;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;
  localparam int AFTH  = 1008;

  logic          clk = 1'b0;
  logic          rst, flush, s_valid, s_ready, m_valid, m_ready;
  logic [DW-1:0] s_data, m_data, ram_dw, ram_qr;
  logic [AW-1:0] ram_aw, ram_ar;
  logic          ram_cew, ram_cer, ram_rst;
  logic [AW:0]   level;
  logic          full, afull, empty;

  fifo_mipi_tx_ctrl #(.AW(AW), .DW(DW), .AFULL_TH(AFTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ram_aw(ram_aw), .ram_dw(ram_dw), .ram_cew(ram_cew),
    .ram_ar(ram_ar), .ram_cer(ram_cer), .ram_qr(ram_qr), .ram_rst(ram_rst),
    .level(level), .full(full), .afull(afull), .empty(empty)
  );

  always #5 clk = ~clk;

  // RAM: synchronous write, 1-cycle read latency
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_cew) mem[ram_aw] <= ram_dw;
    if (ram_cer) ram_qr <= mem[ram_ar];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: ordered list of words accepted and not yet popped
  logic [DW-1:0] q[$];
  bit            mon_en = 1'b0;
  int            pops = 0;
  logic [DW-1:0] last_pop;
  int            last_pop_cyc = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;

  // Monitor / scoreboard: inputs are stable mid-cycle, so negedge sees the exact handshakes
  always @(negedge clk) begin
    if (mon_en) begin
      int sz;
      sz = q.size();
      check("level", level, sz);
      check("full", full, sz == DEPTH);
      check("afull", afull, sz >= AFTH);
      check("empty", empty, sz == 0);
      check("s_ready", s_ready, (sz < DEPTH) && !rst && !flush);
      check("ram_rst", ram_rst, rst | flush);
      check("ram_cew", ram_cew, s_valid && s_ready);
      if (ram_cew) check("ram_dw", ram_dw, s_data);
      if (rst || flush) check("ram_cer_clr", ram_cer, 0);
      if (sz == 0) check("m_valid_when_empty", m_valid, 0);
      if (prev_stall) begin
        check("stall_m_valid", m_valid, 1);
        check("stall_m_data", m_data, prev_data);
      end
      prev_stall = m_valid && !m_ready && !rst && !flush;
      prev_data  = m_data;
      if (m_valid && m_ready) begin
        if (sz == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_order: got pop of 0x%0h required no pop (model empty)", m_data);
        end else begin
          check("pop_data", m_data, q.pop_front());
        end
        pops++;
        last_pop     = m_data;
        last_pop_cyc = cyc;
      end
      if (s_valid && s_ready) q.push_back(s_data);
      if (rst || flush) q.delete();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input int bound, input string name);
    bit done = 1'b0;
    for (int n = 0; n < bound && !done; n++) begin
      @(negedge clk);
      if (empty && !m_valid) done = 1'b1;
    end
    step();
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: drain timeout, got level %0d required 0", name, level);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, guard, t0, t1, p0, pushed;
    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;

    // 1. Reset
    step();
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_s_ready", s_ready, 0);
      check("rst_empty", empty, 1);
      check("rst_level", level, 0);
      check("rst_m_valid", m_valid, 0);
      step();
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", s_ready, 1);

    // 2. Single word latency
    step();
    m_ready = 1'b1; s_valid = 1'b1; s_data = 32'hA5A5_0001;
    @(negedge clk);
    check("single_cew", ram_cew, 1);
    check("single_aw", ram_aw, 0);
    step();
    s_valid = 1'b0;
    @(negedge clk);
    check("single_mv_e0p1", m_valid, 0);
    @(negedge clk);
    check("single_mv_e1p1", m_valid, 0);
    @(negedge clk);
    check("single_mv_e2", m_valid, 1);
    check("single_data", m_data, 32'hA5A5_0001);
    @(negedge clk);
    check("single_level", level, 0);
    step();

    // 3. Fill to full, reject extra push, then drain in order
    m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      s_valid = 1'b1; s_data = i;
      @(negedge clk);
      check("fill_accept", s_ready, 1);
      step();
    end
    s_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_flag", full, 1);
      check("full_afull", afull, 1);
      check("full_s_ready", s_ready, 0);
      check("full_no_write", ram_cew, 0);
      step();
    end
    s_valid = 1'b0;
    p0 = pops;
    m_ready = 1'b1;
    wait_empty(DEPTH + 20, "fill_drain");
    check("fill_drain_count", pops - p0, DEPTH);
    check("fill_drain_last", last_pop, DEPTH - 1);

    // 4. Streaming across address wrap
    p0 = pops; acc = 0; guard = 0; t0 = 0; t1 = 0;
    s_valid = 1'b1; m_ready = 1'b1;
    while (acc < 3000 && guard < 4000) begin
      s_data = $urandom;
      @(negedge clk);
      if (s_ready) begin
        if (acc == 0) t0 = cyc;
        t1 = cyc;
        acc++;
      end
      guard++;
      step();
    end
    s_valid = 1'b0;
    wait_empty(100, "stream_drain");
    check("stream_push_gapless", t1 - t0, 2999);
    check("stream_pop_span", last_pop_cyc - t0, 3002);
    check("stream_count", pops - p0, 3000);

    // 5. Random backpressure
    p0 = pops; pushed = 0;
    for (int n = 0; n < 60000 && pushed < 10000; n++) begin
      s_valid = ($urandom % 10) < 7;
      s_data  = $urandom;
      m_ready = $urandom % 2;
      @(negedge clk);
      if (s_valid && s_ready) pushed++;
      step();
    end
    s_valid = 1'b0; m_ready = 1'b1;
    wait_empty(DEPTH + 20, "random_drain");
    check("random_count", pops - p0, 10000);

    // 6. Flush with a read in flight
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1; s_data = 32'h100 + i;
      step();
    end
    s_valid = 1'b0;
    repeat (4) step();
    m_ready = 1'b1;
    @(negedge clk);
    check("flush_pre_cer", ram_cer, 1);
    step();
    m_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("flush_pre_level", level, 5);
    step();
    flush = 1'b0;
    @(negedge clk);
    check("flush_level", level, 0);
    check("flush_m_valid", m_valid, 0);
    check("flush_m_data", m_data, 0);
    step();
    @(negedge clk);
    check("flush_qr_dropped", m_valid, 0);
    step();
    p0 = pops;
    m_ready = 1'b1; s_valid = 1'b1; s_data = 32'h0000_1234;
    step();
    s_valid = 1'b0;
    wait_empty(20, "flush_drain");
    check("flush_pop_count", pops - p0, 1);
    check("flush_first_pop", last_pop, 32'h0000_1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
